// File: rtl/adder_share_arbiter.sv
// Two-requester arbiter sharing one registered WIDTH-bit adder; result carries requester ID.
// Build option: define ADD_ARB_SAT_EN to saturate the low WIDTH bits and flag overflow in the MSB.
module adder_share_arbiter #(
  parameter int WIDTH      = 8,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  input  logic             res_ready
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH:0]   res_sum_q, res_sum_d;
  logic             res_id_q, res_id_d;

  logic             can_accept;
  logic             pick1;
  logic             grant_any;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH:0]   raw_sum;
  logic [WIDTH:0]   sum_out;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    can_accept = (state_q == EMPTY) | res_ready;

    if (PRIO_FIXED) begin
      pick1 = req1_valid & ~req0_valid;
    end else begin
      // last_grant_q=1 means req1 was served last, so req0 wins a tie.
      pick1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    // Readies are combinational, so gate with rst_n to keep them low in reset.
    grant_any  = rst_n & can_accept & (req0_valid | req1_valid);
    req0_ready = grant_any & ~pick1;
    req1_ready = grant_any & pick1;

    sel_a   = pick1 ? req1_a : req0_a;
    sel_b   = pick1 ? req1_b : req0_b;
    raw_sum = {1'b0, sel_a} + {1'b0, sel_b};
`ifdef ADD_ARB_SAT_EN
    sum_out = raw_sum[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : raw_sum;
`else
    sum_out = raw_sum;
`endif

    state_d      = state_q;
    last_grant_d = last_grant_q;
    res_sum_d    = res_sum_q;
    res_id_d     = res_id_q;

    if (grant_any) begin
      state_d      = FULL;
      last_grant_d = pick1;
      res_sum_d    = sum_out;
      res_id_d     = pick1;
    end else if (res_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      res_sum_q    <= '0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_sum_q    <= res_sum_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: round-robin instance plus a fixed-priority instance.
module tb_adder_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid, res_id, res_ready;
  logic [8:0] res_sum;

  logic       f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic [7:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic       f_res_valid, f_res_id, f_res_ready;
  logic [8:0] f_res_sum;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] fexp_q[$];
  logic [9:0] mon_e, fmon_e;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(8), .PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_id(res_id), .res_ready(res_ready)
  );

  adder_share_arbiter #(.WIDTH(8), .PRIO_FIXED(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_ready(f_req1_ready),
    .res_valid(f_res_valid), .res_sum(f_res_sum), .res_id(f_res_id), .res_ready(f_res_ready)
  );

  function automatic logic [8:0] exp_sum(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef ADD_ARB_SAT_EN
    if (s[8]) s = 9'h1FF;
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop and compare whenever a result is consumed.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("rr_unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rr_res_id", 32'(res_id), 32'(mon_e[9]));
        check("rr_res_sum", 32'(res_sum), 32'(mon_e[8:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && f_res_valid && f_res_ready) begin
      if (fexp_q.size() == 0) begin
        check("fix_unexpected_result", 32'(f_res_valid), 32'd0);
      end else begin
        fmon_e = fexp_q.pop_front();
        check("fix_res_id", 32'(f_res_id), 32'(fmon_e[9]));
        check("fix_res_sum", 32'(f_res_sum), 32'(fmon_e[8:0]));
      end
    end
  end

  // One cycle on the round-robin instance; called at posedge+1.
  task automatic step(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                      input logic rr, input logic er0, input logic er1, input bit push);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
    @(negedge clk);
    check("rr_req0_ready", 32'(req0_ready), 32'(er0));
    check("rr_req1_ready", 32'(req1_ready), 32'(er1));
    if (push && er0) exp_q.push_back({1'b0, exp_sum(a0, b0)});
    if (push && er1) exp_q.push_back({1'b1, exp_sum(a1, b1)});
    @(posedge clk); #1;
  endtask

  task automatic step_fix(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                          input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                          input logic er0, input logic er1);
    f_req0_valid = v0; f_req0_a = a0; f_req0_b = b0;
    f_req1_valid = v1; f_req1_a = a1; f_req1_b = b1;
    f_res_ready  = 1'b1;
    @(negedge clk);
    check("fix_req0_ready", 32'(f_req0_ready), 32'(er0));
    check("fix_req1_ready", 32'(f_req1_ready), 32'(er1));
    if (er0) fexp_q.push_back({1'b0, exp_sum(a0, b0)});
    if (er1) fexp_q.push_back({1'b1, exp_sum(a1, b1)});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01;
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01;
    res_ready = 1'b1;
    f_req0_valid = 1'b0; f_req0_a = '0; f_req0_b = '0;
    f_req1_valid = 1'b0; f_req1_a = '0; f_req1_b = '0;
    f_res_ready = 1'b1;

    // Reset state: outputs cleared, readies held low despite valid requests.
    @(negedge clk);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_res_sum", 32'(res_sum), 32'd0);
    check("reset_res_id", 32'(res_id), 32'd0);
    check("reset_req0_ready", 32'(req0_ready), 32'd0);
    check("reset_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both valid four cycles: grants alternate 0,1,0,1 starting with req0.
    step(1'b1, 8'h01, 8'h02, 1'b1, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h03, 8'h04, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h03, 8'h04, 1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h05, 8'h06, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();

    // Single req0 0x12+0x34.
    step(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    idle();

    // Backpressure: hold 0x0FF three cycles while req1 waits.
    step(1'b1, 8'hF0, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_sum", 32'(res_sum), 32'h0FF);
      check("hold_res_id", 32'(res_id), 32'd0);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    idle();

    // Carry out of the top bit (saturates when the option is built in).
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    idle();

    // Reset while FULL: held result discarded, req0 wins the first tie afterwards.
    step(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_res_valid", 32'(res_valid), 32'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_res_valid", 32'(res_valid), 32'd0);
    check("async_reset_res_sum", 32'(res_sum), 32'd0);
    check("async_reset_req0_ready", 32'(req0_ready), 32'd0);
    check("async_reset_req1_ready", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_res_valid", 32'(res_valid), 32'd0);
    step(1'b1, 8'h05, 8'h05, 1'b1, 8'h06, 8'h06, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1, 8'h06, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    idle();

    // Fixed priority: req0 wins every tie, req1 served only once req0 drops.
    step_fix(1'b1, 8'h02, 8'h03, 1'b1, 8'hAA, 8'h01, 1'b1, 1'b0);
    step_fix(1'b1, 8'h04, 8'h05, 1'b1, 8'hAA, 8'h01, 1'b1, 1'b0);
    step_fix(1'b1, 8'h06, 8'h07, 1'b1, 8'hAA, 8'h01, 1'b1, 1'b0);
    step_fix(1'b0, 8'h00, 8'h00, 1'b1, 8'hAA, 8'h01, 1'b0, 1'b1);
    step_fix(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Drain: bounded wait for all expected results.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || fexp_q.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check("rr_pending_results", 32'(exp_q.size()), 32'd0);
    check("fix_pending_results", 32'(fexp_q.size()), 32'd0);
    check("final_res_valid", 32'(res_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
